// File: rtl/pncorr_seq.sv
// pncorr_seq: PN-code correlator sequencer.
// Registers each strobed 12-bit sample and drives an external add/subtract
// accumulator (B/CE/ACC/SUB) from a programmable chip code. After the last
// chip of every period the accumulator sum is captured into RES and offered
// on a VALID/ACK handshake, with a sticky OVR flag for unacknowledged
// results that get overwritten.
module pncorr_seq #(
  parameter int              LEN  = 16,       // chips per period, 2..64
  parameter logic [LEN-1:0]  CODE = 16'hB38F  // bit 0 is the first chip; 1 = add
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        STB,
  input  logic [11:0] DIN,
  output logic [11:0] B,
  output logic        CE,
  output logic        ACC,
  output logic        SUB,
  input  logic [11:0] Q,
  output logic [11:0] RES,
  output logic        VALID,
  input  logic        ACK,
  output logic        OVR,
  output logic [5:0]  PHASE
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Code widened to the full PHASE range so a 6-bit index always fits.
  localparam logic [63:0] CODE_EXT   = 64'(CODE);
  localparam logic [5:0]  LAST_PHASE = 6'(LEN - 1);

  logic [0:0] state;
  logic       cap_d1;  // last chip strobed; accumulator updates next edge
  logic       cap_d2;  // accumulator now holds the final sum

  // Sequencer: run/idle control, chip counter and accumulator drive.
  // NOTE: every register here uses non-blocking assignments so all of them
  // sample the pre-edge values of PHASE, state and the capture pipe together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      PHASE  <= '0;
      B      <= '0;
      CE     <= 1'b0;
      ACC    <= 1'b0;
      SUB    <= 1'b0;
      cap_d1 <= 1'b0;
      cap_d2 <= 1'b0;
    end else if (!EN) begin
      // Abandon any partial period; the result side is left untouched.
      state  <= ST_IDLE;
      PHASE  <= '0;
      CE     <= 1'b0;
      cap_d1 <= 1'b0;
      cap_d2 <= 1'b0;
    end else if (state == ST_IDLE) begin
      // A strobe on the enabling edge is ignored; chip 0 is the next one.
      state  <= ST_RUN;
      PHASE  <= '0;
      CE     <= 1'b0;
      cap_d1 <= 1'b0;
      cap_d2 <= cap_d1;
    end else begin
      cap_d2 <= cap_d1;
      if (STB) begin
        B      <= DIN;
        CE     <= 1'b1;
        ACC    <= (PHASE != 6'd0);
        SUB    <= ~CODE_EXT[PHASE];
        PHASE  <= (PHASE == LAST_PHASE) ? 6'd0 : PHASE + 6'd1;
        cap_d1 <= (PHASE == LAST_PHASE);
      end else begin
        CE     <= 1'b0;
        cap_d1 <= 1'b0;
      end
    end
  end

  // Result capture and handshake; a capture beats a same-edge ACK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RES   <= '0;
      VALID <= 1'b0;
      OVR   <= 1'b0;
    end else if (cap_d2) begin
      RES   <= Q;
      VALID <= 1'b1;
      if (VALID && !ACK) OVR <= 1'b1;
    end else if (VALID && ACK) begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pncorr_seq.sv
// tb_pncorr_seq: directed bench for pncorr_seq. Three LEN=4 instances with
// codes 1010, 0000 and 1111 share one stimulus stream; each drives its own
// behavioural model of the downstream 12-bit add/subtract accumulator.
module tb_pncorr_seq;

  localparam int U_ALT = 0;  // CODE = 4'b1010
  localparam int U_NEG = 1;  // CODE = 4'b0000
  localparam int U_ONE = 2;  // CODE = 4'b1111

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        stb = 1'b0;
  logic [11:0] din = '0;
  logic        ack = 1'b0;

  logic [11:0] b_o     [3];
  logic        ce_o    [3];
  logic        acc_o   [3];
  logic        sub_o   [3];
  logic [11:0] q_i     [3];
  logic [11:0] res_o   [3];
  logic        valid_o [3];
  logic        ovr_o   [3];
  logic [5:0]  phase_o [3];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pncorr_seq #(.LEN(4), .CODE(4'b1010)) u_alt (
    .CLK(clk), .RST(rst), .EN(en), .STB(stb), .DIN(din),
    .B(b_o[U_ALT]), .CE(ce_o[U_ALT]), .ACC(acc_o[U_ALT]), .SUB(sub_o[U_ALT]),
    .Q(q_i[U_ALT]), .RES(res_o[U_ALT]), .VALID(valid_o[U_ALT]), .ACK(ack),
    .OVR(ovr_o[U_ALT]), .PHASE(phase_o[U_ALT])
  );

  pncorr_seq #(.LEN(4), .CODE(4'b0000)) u_neg (
    .CLK(clk), .RST(rst), .EN(en), .STB(stb), .DIN(din),
    .B(b_o[U_NEG]), .CE(ce_o[U_NEG]), .ACC(acc_o[U_NEG]), .SUB(sub_o[U_NEG]),
    .Q(q_i[U_NEG]), .RES(res_o[U_NEG]), .VALID(valid_o[U_NEG]), .ACK(ack),
    .OVR(ovr_o[U_NEG]), .PHASE(phase_o[U_NEG])
  );

  pncorr_seq #(.LEN(4), .CODE(4'b1111)) u_one (
    .CLK(clk), .RST(rst), .EN(en), .STB(stb), .DIN(din),
    .B(b_o[U_ONE]), .CE(ce_o[U_ONE]), .ACC(acc_o[U_ONE]), .SUB(sub_o[U_ONE]),
    .Q(q_i[U_ONE]), .RES(res_o[U_ONE]), .VALID(valid_o[U_ONE]), .ACK(ack),
    .OVR(ovr_o[U_ONE]), .PHASE(phase_o[U_ONE])
  );

  // Downstream accumulator models: Q <= (ACC ? Q : 0) + (SUB ? -B : B).
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst)
        q_i[k] <= '0;
      else if (ce_o[k])
        q_i[k] <= (acc_o[k] ? q_i[k] : 12'd0) + (sub_o[k] ? -b_o[k] : b_o[k]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int k, input string tag);
    check({tag, "_b"},     32'(b_o[k]),     32'h0);
    check({tag, "_ce"},    32'(ce_o[k]),    32'h0);
    check({tag, "_acc"},   32'(acc_o[k]),   32'h0);
    check({tag, "_sub"},   32'(sub_o[k]),   32'h0);
    check({tag, "_res"},   32'(res_o[k]),   32'h0);
    check({tag, "_valid"}, 32'(valid_o[k]), 32'h0);
    check({tag, "_ovr"},   32'(ovr_o[k]),   32'h0);
    check({tag, "_phase"}, 32'(phase_o[k]), 32'h0);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // 12 back-to-back strobes DIN=1..12 on the all-ones code instance.
  task automatic run_stream(input logic ack_val, input string tag);
    logic [11:0] exp_res;
    logic        exp_ovr;
    ack = ack_val;
    for (int e = 1; e <= 14; e++) begin
      stb = (e <= 12);
      din = 12'(e);
      tick();
      if (e == 1 || e == 5 || e == 9)
        check($sformatf("%s_acc_chip0_e%0d", tag, e), 32'(acc_o[U_ONE]), 32'h0);
      if (e == 6 || e == 10 || e == 14) begin
        exp_res = (e == 6) ? 12'h00A : (e == 10) ? 12'h01A : 12'h02A;
        exp_ovr = ack_val ? 1'b0 : (e >= 10);
        check($sformatf("%s_res_e%0d", tag, e),   32'(res_o[U_ONE]),   32'(exp_res));
        check($sformatf("%s_valid_e%0d", tag, e), 32'(valid_o[U_ONE]), 32'h1);
        check($sformatf("%s_ovr_e%0d", tag, e),   32'(ovr_o[U_ONE]),   32'(exp_ovr));
      end
    end
    stb = 1'b0;
    tick();
    ack = 1'b0;
  endtask

  int          basic_din [4] = '{10, 20, 30, 40};
  logic        basic_sub [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int          tail_din  [8] = '{10, 20, 30, 40, 1, 2, 3, 4};

  initial begin
    // Asynchronous reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check_reset(U_ALT, "por");
    tick();
    tick();
    rst = 1'b0;

    // Basic: CODE 1010, DIN 10..40 -> -10+20-30+40 = 20.
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1;
      din = 12'(basic_din[i]);
      tick();
      check($sformatf("basic_sub%0d", i), 32'(sub_o[U_ALT]), 32'(basic_sub[i]));
      check($sformatf("basic_acc%0d", i), 32'(acc_o[U_ALT]), 32'(i != 0));
      check($sformatf("basic_b%0d", i),   32'(b_o[U_ALT]),   32'(basic_din[i]));
    end
    stb = 1'b0;
    tick();
    check("basic_valid_early", 32'(valid_o[U_ALT]), 32'h0);
    tick();
    check("basic_valid", 32'(valid_o[U_ALT]), 32'h1);
    check("basic_res",   32'(res_o[U_ALT]),   32'h014);

    // Negative/wrap: CODE 0000, 4 x 0x7FF -> -8188 mod 4096 = 4.
    ack_pulse();
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1;
      din = 12'h7FF;
      tick();
    end
    stb = 1'b0;
    tick();
    tick();
    check("wrap_res",   32'(res_o[U_NEG]),   32'h004);
    check("wrap_valid", 32'(valid_o[U_NEG]), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("wrap_ack_clears", 32'(valid_o[U_NEG]), 32'h0);

    // Back-to-back with ACK held, then the same stream with no ACK.
    run_stream(1'b1, "b2b");
    run_stream(1'b0, "ovr");

    // Abort after the 2nd chip, then a clean restart.
    ack_pulse();
    for (int i = 0; i < 2; i++) begin
      stb = 1'b1;
      din = 12'(5 + i);
      tick();
    end
    check("abort_phase_mid", 32'(phase_o[U_ALT]), 32'h2);
    stb = 1'b0;
    en  = 1'b0;
    tick();
    check("abort_phase", 32'(phase_o[U_ALT]), 32'h0);
    check("abort_ce",    32'(ce_o[U_ALT]),    32'h0);
    tick();
    tick();
    tick();
    check("abort_no_capture", 32'(valid_o[U_ALT]), 32'h0);
    en  = 1'b1;
    stb = 1'b1;
    din = 12'd99;
    tick();
    check("enable_edge_stb_ignored", 32'(ce_o[U_ALT]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1;
      din = 12'(basic_din[i]);
      tick();
      if (i == 0) begin
        check("restart_acc",   32'(acc_o[U_ALT]),   32'h0);
        check("restart_sub",   32'(sub_o[U_ALT]),   32'h1);
        check("restart_phase", 32'(phase_o[U_ALT]), 32'h1);
      end
    end
    stb = 1'b0;
    tick();
    tick();
    check("restart_res",   32'(res_o[U_ALT]),   32'h014);
    check("restart_valid", 32'(valid_o[U_ALT]), 32'h1);

    // Asynchronous reset mid-period with VALID=1 on u_alt and OVR=1 on u_one.
    for (int i = 0; i < 2; i++) begin
      stb = 1'b1;
      din = 12'(i + 1);
      tick();
    end
    stb = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset(U_ALT, "arst");
    check("arst_ovr_one", 32'(ovr_o[U_ONE]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Two back-to-back periods; ACK lands on the second capture edge.
    for (int e = 1; e <= 11; e++) begin
      stb = (e <= 8);
      din = (e <= 8) ? 12'(tail_din[e-1]) : 12'd0;
      ack = (e >= 10);
      tick();
      if (e == 1) begin
        check("post_rst_acc",   32'(acc_o[U_ALT]),   32'h0);
        check("post_rst_sub",   32'(sub_o[U_ALT]),   32'h1);
        check("post_rst_phase", 32'(phase_o[U_ALT]), 32'h1);
      end
      if (e == 6) begin
        check("tail_res1",   32'(res_o[U_ALT]),   32'h014);
        check("tail_valid1", 32'(valid_o[U_ALT]), 32'h1);
      end
      if (e == 10) begin
        check("same_edge_valid", 32'(valid_o[U_ALT]), 32'h1);
        check("same_edge_res",   32'(res_o[U_ALT]),   32'h002);
        check("same_edge_ovr",   32'(ovr_o[U_ALT]),   32'h0);
      end
      if (e == 11)
        check("same_edge_ack_next", 32'(valid_o[U_ALT]), 32'h0);
    end
    ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
